// File: rtl/wam_pkg.sv
// Shared constants and state encoding for the whack-a-mole scoring slice.
package wam_pkg;

    localparam logic [3:0] NO_LIGHT   = 4'd15;
    localparam int         NUM_LIGHTS = 9;
    localparam int         MAX_LIVES  = 9;
    localparam int         SCORE_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } light_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Turns the raw key-held level into a single-cycle press event plus the key
// that was held when the press was recognised.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic       press,
    output logic [3:0] key_latched
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             level;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive samples that disagree with the debounced level;
    // one agreeing sample restarts the run, so glitches never accumulate.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            level       <= 1'b0;
            cnt         <= '0;
            press       <= 1'b0;
            key_latched <= 4'd0;
        end else begin
            press <= 1'b0;
            if (key_valid == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= key_valid;
                if (key_valid) begin
                    press       <= 1'b1;
                    key_latched <= key;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hit_scorer.sv
// Scores keypad presses against the currently lit light: hits, misses and
// optional lives, with a per-light IDLE/ARMED/LOCKED state machine.
module hit_scorer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MAX_LIVES       = wam_pkg::MAX_LIVES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic [3:0] light_pos,
    input  logic       light_new,
    input  logic       load_lives,
    input  logic [3:0] lives_init,
    input  logic       use_lives,
    output logic [5:0] points,
    output logic [5:0] misses,
    output logic [3:0] lives_left,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       out_of_lives
);

    import wam_pkg::*;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [3:0]         LIVES_MAX = 4'(MAX_LIVES);
    localparam logic [3:0]         POS_LIMIT = 4'(NUM_LIGHTS);

    logic         press;
    logic [3:0]   press_key;
    logic [3:0]   target;
    logic         hit;
    logic         miss;
    light_state_t state, state_next;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_valid  (key_valid),
        .key        (key),
        .press      (press),
        .key_latched(press_key)
    );

    assign out_of_lives = use_lives && (lives_left == 4'd0);

    // Priority: load_lives, then enable, then light_new, then a press.
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        miss       = 1'b0;
        if (load_lives || !enable) begin
            state_next = ST_IDLE;
        end else if (light_new) begin
            miss       = (state == ST_ARMED);
            state_next = (light_pos < POS_LIMIT) ? ST_ARMED : ST_IDLE;
        end else if (press && state == ST_ARMED) begin
            if (press_key == target) begin
                hit        = 1'b1;
                state_next = ST_LOCKED;
            end else begin
                miss = 1'b1;
            end
        end
        if (out_of_lives) begin
            hit  = 1'b0;
            miss = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            target <= 4'd0;
        end else begin
            state <= state_next;
            if (enable && !load_lives && light_new && light_pos < POS_LIMIT)
                target <= light_pos;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            points     <= '0;
            misses     <= '0;
            lives_left <= 4'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else if (load_lives) begin
            points     <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (lives_init == 4'd0)
                lives_left <= 4'd1;
            else if (lives_init > LIVES_MAX)
                lives_left <= LIVES_MAX;
            else
                lives_left <= lives_init;
        end else begin
            hit_pulse  <= hit;
            miss_pulse <= miss;
            if (hit && points != SCORE_MAX)
                points <= points + 1'b1;
            if (miss) begin
                if (misses != SCORE_MAX)
                    misses <= misses + 1'b1;
                if (use_lives && lives_left != 4'd0)
                    lives_left <= lives_left - 1'b1;
            end
        end
    end

endmodule

// File: doc/hit_scorer.md
HIT_SCORER -- requirements
Module: hit_scorer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable cycles of key_valid that make up one debounced edge (5 ms at 50 MHz).
REQ-002 Parameter MAX_LIVES, default 9, is the upper clamp for loaded lives.
REQ-003 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 enable  in  1  high while the game is in PLAY; scoring is frozen when low.
REQ-006 key_valid  in  1  raw key-held level from the keypad scanner.
REQ-007 key  in  4  index of the held key, 0..8.
REQ-008 light_pos  in  4  index of the lit light, 0..8; 4'd15 means no light.
REQ-009 light_new  in  1  single-cycle pulse when a new light turns on.
REQ-010 load_lives  in  1  single-cycle pulse that starts a game round.
REQ-011 lives_init  in  4  requested lives, sampled on load_lives.
REQ-012 use_lives  in  1  lives mode select.
REQ-013 points  out  6  successful hits.
REQ-014 misses  out  6  expired or wrong presses.
REQ-015 lives_left  out  4  remaining lives.
REQ-016 hit_pulse  out  1  one-cycle pulse per scored hit.
REQ-017 miss_pulse  out  1  one-cycle pulse per miss.
REQ-018 out_of_lives  out  1  high when use_lives=1 and lives_left=0.

Function
REQ-019 The debouncer SHALL emit one press event when key_valid has been high for DEBOUNCE_CYCLES consecutive cycles, and it SHALL re-arm only after key_valid has been low for DEBOUNCE_CYCLES consecutive cycles.
REQ-020 key SHALL be latched in the press-event cycle; a held key SHALL never produce a second event.
REQ-021 The per-light FSM SHALL have states IDLE, ARMED and LOCKED.
  - IDLE: no scorable light.
  - ARMED: light lit and not yet hit.
  - LOCKED: light already hit.
REQ-022 On light_new with light_pos<=8, the FSM SHALL go to ARMED from any state and latch light_pos as the target.
REQ-023 On light_new with light_pos>8, the FSM SHALL go to IDLE.
REQ-024 If light_new arrives while in ARMED, the expiry SHALL count as one miss.
REQ-025 In ARMED, a press event with key equal to the target SHALL:
  - move the FSM to LOCKED;
  - increment points;
  - assert hit_pulse.
REQ-026 In ARMED, a press event with a mismatched key SHALL count as one miss and the FSM SHALL stay in ARMED.
REQ-027 Press events in IDLE or LOCKED SHALL be ignored, with no count change.
REQ-028 When light_new and a press event coincide, light_new SHALL win: the press is discarded, and an expiry miss is counted if the FSM was in ARMED.
REQ-029 A miss SHALL:
  - increment misses;
  - assert miss_pulse;
  - decrement lives_left only when use_lives=1 and lives_left>0.
REQ-030 Latency: a press event or light_new in cycle N SHALL update the counters and pulses in cycle N+1.
REQ-031 points and misses SHALL saturate at 63; lives_left SHALL saturate at 0.
REQ-032 Each cycle SHALL produce at most one hit or one miss.
REQ-033 load_lives SHALL:
  - clear points and misses;
  - force the FSM to IDLE;
  - load lives_left with lives_init clamped to 1..MAX_LIVES (0 loads 1; values above MAX_LIVES load MAX_LIVES).
REQ-034 load_lives SHALL take priority over all other events in the same cycle.
REQ-035 While enable=0:
  - the FSM SHALL be held in IDLE;
  - counters SHALL hold their values;
  - pulses SHALL be 0;
  - the debouncer SHALL keep tracking so that no stale event fires when enable rises.
REQ-036 When out_of_lives=1, no further hits or misses SHALL be counted until load_lives.

Reset
REQ-037 reset low SHALL asynchronously force:
  - points=0, misses=0, lives_left=0;
  - hit_pulse=0, miss_pulse=0;
  - FSM to IDLE;
  - debounce counter to 0, debouncer disarmed-low, latched key=0.
REQ-038 reset asserted mid-game SHALL discard any pending press event.
REQ-039 After reset, use_lives=1 SHALL yield out_of_lives=1 until load_lives.

Structure
REQ-040 The shared package wam_pkg SHALL hold the following constants:
  - NO_LIGHT=4'd15;
  - NUM_LIGHTS=9;
  - MAX_LIVES default 9;
  - SCORE_W=6;
  - the FSM state encoding.
REQ-041 Debouncing SHALL live in one sub-module, key_debouncer, that outputs a single-cycle press event and the latched key.

Verification (DEBOUNCE_CYCLES=4 on the bench)
REQ-042 Bench SHALL run a basic hit:
  - stimulus: load_lives with lives_init=3; light_new with light_pos=5; key=5 held for 6 cycles;
  - response: points=1, exactly one hit_pulse, misses=0.
REQ-043 Bench SHALL run a bounce check:
  - stimulus: key_valid toggling with 2-cycle high glitches, then held for 10 cycles, while light_pos=2 and key=2;
  - response: exactly one hit, points=1.
REQ-044 Bench SHALL run a wrong key plus expiry in lives mode:
  - stimulus: use_lives=1, lives_init=3, light_pos=4, press key=7, then light_new with light_pos=1 and no press;
  - response: misses=2, lives_left=1.
REQ-045 Bench SHALL run a double press on the same light:
  - stimulus: two debounced presses of the target key;
  - response: points=1; the second press is ignored because the FSM is in LOCKED.
REQ-046 Bench SHALL run saturation and clamp:
  - stimulus: lives_init=0, then lives_init=12 (MAX_LIVES=9); separately, 70 hits;
  - response: lives_left=1 and 9 respectively; points stops at 63.
REQ-047 Bench SHALL run coincidence and reset:
  - stimulus: light_new and a press event in the same cycle while in ARMED; then reset pulsed low mid-debounce;
  - response: the coincidence counts one miss and no hit; after reset all outputs are 0 and the FSM is IDLE.
